// File: rtl/bus_pkg.sv
// Shared types for the CPU bus responder: target encoding, FSM states and the
// priority encoder that turns decoder enables into one latched target.
package bus_pkg;

  typedef enum logic [2:0] {
    TGT_RAM    = 3'd0,
    TGT_VDP    = 3'd1,
    TGT_STATUS = 3'd2,
    TGT_DSP    = 3'd3,
    TGT_PAD    = 3'd4,
    TGT_FLASH  = 3'd5
  } tgt_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StFlash = 2'd2,
    StAck   = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

  // Flash wins over everything so a shadowed RAM window still reads flash.
  function automatic tgt_e sel_target(input logic flash, input logic ram, input logic vdp,
                                      input logic status, input logic dsp);
    if (flash)       return TGT_FLASH;
    else if (ram)    return TGT_RAM;
    else if (vdp)    return TGT_VDP;
    else if (status) return TGT_STATUS;
    else if (dsp)    return TGT_DSP;
    else             return TGT_PAD;
  endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus bundle between the decoder/target fabric and the responder.
interface cpu_bus_responder_if;
  logic        cpu_mem_valid;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ram_en;
  logic        vdp_en;
  logic        status_en;
  logic        dsp_en;
  logic        pad_en;
  logic        flash_read_en;
  logic [31:0] cpu_ram_rdata;
  logic [31:0] vdp_rdata;
  logic [31:0] status_rdata;
  logic [31:0] dsp_rdata;
  logic [31:0] pad_rdata;
  logic [31:0] flash_rdata;
  logic        flash_read_ready;
  logic        cpu_mem_ready;
  logic [31:0] cpu_rdata;
  logic        bus_error;

  modport master (
    output cpu_mem_valid, cpu_wstrb, cpu_ram_en, vdp_en, status_en, dsp_en, pad_en,
           flash_read_en, cpu_ram_rdata, vdp_rdata, status_rdata, dsp_rdata, pad_rdata,
           flash_rdata, flash_read_ready,
    input  cpu_mem_ready, cpu_rdata, bus_error
  );

  modport slave (
    input  cpu_mem_valid, cpu_wstrb, cpu_ram_en, vdp_en, status_en, dsp_en, pad_en,
           flash_read_en, cpu_ram_rdata, vdp_rdata, status_rdata, dsp_rdata, pad_rdata,
           flash_rdata, flash_read_ready,
    output cpu_mem_ready, cpu_rdata, bus_error
  );
endinterface

// File: rtl/bus_wait_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module bus_wait_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cpu_bus_responder.sv
// Sequences cpu_mem_ready for the decoded target (fixed wait states or flash
// handshake), returns registered read data and force-terminates hung accesses.
module cpu_bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned RAM_WAIT    = 0,
  parameter int unsigned VDP_WAIT    = 1,
  parameter int unsigned STATUS_WAIT = 0,
  parameter int unsigned DSP_WAIT    = 1,
  parameter int unsigned PAD_WAIT    = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic                 clk,
  input logic                 reset,
  cpu_bus_responder_if.slave  bus
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      r_state, w_state_d;
  tgt_e        r_tgt, w_tgt_d, w_sel_tgt;
  logic        r_is_write, w_is_write_d;
  logic [7:0]  r_to, w_to_d;
  logic [31:0] r_rdata, w_rdata_d, w_tgt_rdata;
  logic        r_ready, w_ready_d;
  logic        r_err, w_err_d;
  logic        w_any_en;
  logic        w_wc_load, w_wc_dec, w_wc_zero;
  logic [7:0]  w_wc_load_val;

  function automatic logic [7:0] wait_for(input tgt_e t);
    unique case (t)
      TGT_RAM:    return 8'(RAM_WAIT);
      TGT_VDP:    return 8'(VDP_WAIT);
      TGT_STATUS: return 8'(STATUS_WAIT);
      TGT_DSP:    return 8'(DSP_WAIT);
      TGT_PAD:    return 8'(PAD_WAIT);
      default:    return 8'd0;
    endcase
  endfunction

  assign w_any_en = bus.flash_read_en | bus.cpu_ram_en | bus.vdp_en | bus.status_en |
                    bus.dsp_en | bus.pad_en;
  assign w_sel_tgt = sel_target(bus.flash_read_en, bus.cpu_ram_en, bus.vdp_en,
                                bus.status_en, bus.dsp_en);
  assign w_wc_load_val = wait_for(w_sel_tgt);

  always_comb begin
    w_tgt_rdata = '0;
    unique case (r_tgt)
      TGT_RAM:    w_tgt_rdata = bus.cpu_ram_rdata;
      TGT_VDP:    w_tgt_rdata = bus.vdp_rdata;
      TGT_STATUS: w_tgt_rdata = bus.status_rdata;
      TGT_DSP:    w_tgt_rdata = bus.dsp_rdata;
      TGT_PAD:    w_tgt_rdata = bus.pad_rdata;
      TGT_FLASH:  w_tgt_rdata = bus.flash_rdata;
      default:    w_tgt_rdata = '0;
    endcase
  end

  bus_wait_counter #(
    .Width (8)
  ) u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_wc_load),
    .i_load_val (w_wc_load_val),
    .i_dec      (w_wc_dec),
    .o_zero     (w_wc_zero)
  );

  always_comb begin
    w_state_d    = r_state;
    w_tgt_d      = r_tgt;
    w_is_write_d = r_is_write;
    w_to_d       = r_to;
    w_rdata_d    = r_rdata;
    w_ready_d    = 1'b0;
    w_err_d      = 1'b0;
    w_wc_load    = 1'b0;
    w_wc_dec     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.cpu_mem_valid && w_any_en) begin
          w_tgt_d      = w_sel_tgt;
          w_is_write_d = (bus.cpu_wstrb != 4'h0);
          w_to_d       = 8'd0;
          w_wc_load    = 1'b1;
          w_state_d    = (w_sel_tgt == TGT_FLASH) ? StFlash : StWait;
        end else if (bus.cpu_mem_valid) begin
          // Unmapped: nobody will answer, so count toward a forced completion.
          if (r_to == TimeoutCnt) begin
            w_state_d = StAck;
            w_rdata_d = TIMEOUT_RDATA;
            w_ready_d = 1'b1;
            w_err_d   = 1'b1;
            w_to_d    = 8'd0;
          end else begin
            w_to_d = r_to + 8'd1;
          end
        end else begin
          w_to_d = 8'd0;
        end
      end
      StWait: begin
        if (!bus.cpu_mem_valid) begin
          w_state_d = StIdle;
        end else if (w_wc_zero) begin
          if (!r_is_write) w_rdata_d = w_tgt_rdata;
          w_state_d = StAck;
          w_ready_d = 1'b1;
        end else begin
          w_wc_dec = 1'b1;
        end
      end
      StFlash: begin
        if (!bus.cpu_mem_valid) begin
          w_state_d = StIdle;
          w_to_d    = 8'd0;
        end else if (bus.flash_read_ready) begin
          if (!r_is_write) w_rdata_d = bus.flash_rdata;
          w_state_d = StAck;
          w_ready_d = 1'b1;
        end else if (r_to == TimeoutCnt) begin
          w_state_d = StAck;
          w_rdata_d = TIMEOUT_RDATA;
          w_ready_d = 1'b1;
          w_err_d   = 1'b1;
          w_to_d    = 8'd0;
        end else begin
          w_to_d = r_to + 8'd1;
        end
      end
      StAck: begin
        // Decoder still shows the completing access here, so enables are ignored.
        w_state_d = StIdle;
        w_to_d    = 8'd0;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_tgt      <= TGT_RAM;
      r_is_write <= 1'b0;
      r_to       <= 8'd0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_tgt      <= w_tgt_d;
      r_is_write <= w_is_write_d;
      r_to       <= w_to_d;
      r_rdata    <= w_rdata_d;
      r_ready    <= w_ready_d;
      r_err      <= w_err_d;
    end
  end

  assign bus.cpu_mem_ready = r_ready;
  assign bus.cpu_rdata     = r_rdata;
  assign bus.bus_error     = r_err;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench: stimulus pushes expected completions, a negedge monitor pops
// and checks cycle, data and error flag of every ready pulse.
module tb_cpu_bus_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_bus_responder_if bus_if ();

  cpu_bus_responder #(
    .RAM_WAIT    (0),
    .VDP_WAIT    (1),
    .STATUS_WAIT (0),
    .DSP_WAIT    (3),
    .PAD_WAIT    (2),
    .TIMEOUT     (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // en = {flash, ram, vdp, status, dsp, pad}
  task automatic drive(input logic v, input logic [5:0] en, input logic [3:0] wstrb);
    bus_if.cpu_mem_valid = v;
    bus_if.flash_read_en = en[5];
    bus_if.cpu_ram_en    = en[4];
    bus_if.vdp_en        = en[3];
    bus_if.status_en     = en[2];
    bus_if.dsp_en        = en[1];
    bus_if.pad_en        = en[0];
    bus_if.cpu_wstrb     = wstrb;
  endtask

  task automatic access(input logic [5:0] en, input logic [3:0] wstrb, input int lat,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit keep);
    exp_t e;
    drive(1'b1, en, wstrb);
    e.cyc = cyc + lat; e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    repeat (lat + 1) @(posedge clk);
    #1;
    if (!keep) drive(1'b0, 6'b0, 4'h0);
  endtask

  task automatic flash_access(input logic [5:0] en, input int k, input logic [31:0] data);
    exp_t e;
    drive(1'b1, en, 4'h0);
    e.cyc = cyc + k + 1; e.rdata = data; e.err = 1'b0;
    sb.push_back(e);
    repeat (k) @(posedge clk);
    #1;
    bus_if.flash_read_ready = 1'b1;
    bus_if.flash_rdata      = data;
    @(posedge clk);
    #1;
    bus_if.flash_read_ready = 1'b0;
    bus_if.flash_rdata      = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    drive(1'b0, 6'b0, 4'h0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.cpu_mem_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'(bus_if.cpu_mem_ready), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ready_cycle", 32'(cyc), 32'(e.cyc));
          check("rdata", bus_if.cpu_rdata, e.rdata);
          check("bus_error", 32'(bus_if.bus_error), 32'(e.err));
        end
      end else if (bus_if.bus_error) begin
        check("error_without_ready", 32'(bus_if.bus_error), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 6'b0, 4'h0);
    bus_if.flash_read_ready = 1'b0;
    bus_if.cpu_ram_rdata    = 32'h0;
    bus_if.vdp_rdata        = 32'hDEADBEEF;
    bus_if.status_rdata     = 32'h5A5A0001;
    bus_if.dsp_rdata        = 32'h0D5F0123;
    bus_if.pad_rdata        = 32'h000000AB;
    bus_if.flash_rdata      = 32'hBAD0BAD0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(bus_if.cpu_mem_ready), 32'h0);
    check("reset_error", 32'(bus_if.bus_error), 32'h0);
    check("reset_rdata", bus_if.cpu_rdata, 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // RAM read, zero wait
    bus_if.cpu_ram_rdata = 32'h12345678;
    access(6'b010000, 4'h0, 2, 32'h12345678, 1'b0, 1'b0);
    // VDP write keeps previous read data
    access(6'b001000, 4'hF, 3, 32'h12345678, 1'b0, 1'b0);
    // Flash read, ready strobe in cycle 6
    flash_access(6'b100000, 6, 32'hCAFEF00D);
    // Status then pad back-to-back with valid held
    access(6'b000100, 4'h0, 2, 32'h5A5A0001, 1'b0, 1'b1);
    access(6'b000001, 4'h0, 4, 32'h000000AB, 1'b0, 1'b0);
    // DSP read, 3 wait states
    access(6'b000010, 4'h0, 5, 32'h0D5F0123, 1'b0, 1'b0);
    // Unmapped: timeout 16 -> ready 17 cycles after counting starts
    access(6'b000000, 4'h0, 17, 32'h0, 1'b1, 1'b0);
    // RAM and flash together: flash wins
    bus_if.cpu_ram_rdata = 32'h77777777;
    flash_access(6'b110000, 3, 32'h0F1A5400);
    // Flash never answers: counting starts in cycle 1
    access(6'b100000, 4'h0, 18, 32'h0, 1'b1, 1'b0);
    bus_if.cpu_ram_rdata = 32'h33334444;
    access(6'b010000, 4'h0, 2, 32'h33334444, 1'b0, 1'b0);

    // Flash abort: valid drops, late strobe must be ignored
    drive(1'b1, 6'b100000, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 6'b0, 4'h0);
    @(posedge clk);
    #1;
    bus_if.flash_read_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.flash_read_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a DSP wait
    drive(1'b1, 6'b000010, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_ready", 32'(bus_if.cpu_mem_ready), 32'h0);
    check("midreset_error", 32'(bus_if.bus_error), 32'h0);
    check("midreset_rdata", bus_if.cpu_rdata, 32'h0);
    drive(1'b0, 6'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    bus_if.cpu_ram_rdata = 32'h11112222;
    access(6'b010000, 4'h0, 2, 32'h11112222, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Downstream companion to the CPU address decoder: consumes the decoder's per-target enables, sequences `cpu_mem_ready` with per-target wait states or a flash handshake, and returns the selected target's read data to the CPU. It also terminates unmapped or hung accesses with a timeout, so the CPU never stalls forever.

## Interface
Parameters:
- `RAM_WAIT`, 0: extra cycles before ready for CPU RAM.
- `VDP_WAIT`, 1: extra cycles for VDP.
- `STATUS_WAIT`, 0: extra cycles for status regs.
- `DSP_WAIT`, 1: extra cycles for DSP.
- `PAD_WAIT`, 0: extra cycles for pad.
- `TIMEOUT`, 255: cycles before an unanswered access is force-terminated (8-bit counter; legal range 1..255).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `cpu_mem_valid` in 1: CPU request.
- `cpu_wstrb` in 4: nonzero means write.
- `cpu_ram_en`, `vdp_en`, `status_en`, `dsp_en`, `pad_en`, `flash_read_en` in 1 each: decoder outputs.
- `cpu_ram_rdata`, `vdp_rdata`, `status_rdata`, `dsp_rdata`, `pad_rdata`, `flash_rdata` in 32 each: target read data.
- `flash_read_ready` in 1: flash controller data-valid strobe.
- `cpu_mem_ready` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: registered read data, valid with ready.
- `bus_error` out 1: one-cycle pulse coincident with a timeout-forced ready.

## Operation
States:
- **IDLE**: on `cpu_mem_valid`:
  - Target selection: if any enable is high, latch one target by priority flash > ram > vdp > status > dsp > pad.
  - Counter load: load the wait counter with that target's `*_WAIT` and clear the timeout counter.
  - Next state: go to FLASH for flash, else WAIT.
  - Unmapped access: with valid high and no enable, stay in IDLE and increment the timeout counter.
- **WAIT**:
  - Counter: decrement each cycle.
  - Completion: when the counter is 0, capture `cpu_rdata` and go to ACK.
- **FLASH**:
  - Completion: on `flash_read_ready`, capture `flash_rdata` and go to ACK.
  - Timeout counting: otherwise increment the timeout counter.
- **ACK**:
  - Outputs: `cpu_mem_ready`=1 for exactly this cycle.
  - Next state: go to IDLE.
  - Enables: ignored this cycle, since the decoder is combinational and still shows the completing access.

Timeout:
- Trigger: the timeout counter reaching `TIMEOUT` in IDLE (unmapped) or FLASH.
- Response: go to ACK with `cpu_rdata`=0 and `bus_error`=1 in the ACK cycle.

Read data:
- Reads (`cpu_wstrb`==0): `cpu_rdata` is loaded from the latched target.
- Writes: `cpu_rdata` holds its previous value.
- Timing: write and read complete with identical timing.

Aborts and reset:
- Valid dropped: if `cpu_mem_valid` falls in WAIT or FLASH, return to IDLE with no ready and no error. A late `flash_read_ready` is then ignored.
- Reset: asynchronous reset at any point forces IDLE. Counters go to 0, `cpu_mem_ready`=0, `bus_error`=0, `cpu_rdata`=0.

## Timing
- Cycle numbering: cycle 0 is the first cycle with valid and an enable, as seen in IDLE.
- Fixed-latency targets: `cpu_mem_ready` is high in cycle N+2, where N is the target's `*_WAIT`. Zero-wait RAM is ready in cycle 2.
- Flash: `flash_read_ready` high in cycle k (k≥1) gives ready in cycle k+1.
- Timeout: ready with `bus_error` arrives `TIMEOUT`+1 cycles after counting starts.
- Registered outputs: all outputs come directly from flops, with no combinational path from inputs to outputs.
- Back-to-back: a new request is accepted in the first IDLE cycle after ACK.

## Structure
- Shared package `bus_pkg`:
  - target encoding enum (`TGT_RAM`, `TGT_VDP`, `TGT_STATUS`, `TGT_DSP`, `TGT_PAD`, `TGT_FLASH`, 3 bits);
  - FSM state enum (IDLE/WAIT/FLASH/ACK);
  - `TIMEOUT_RDATA` = 32'h0.
- Sub-module `bus_wait_counter`: loadable down-counter with a zero flag, used for the per-target wait. The timeout counter stays inline.

## Test plan
- RAM read, `RAM_WAIT`=0, `cpu_ram_rdata`=32'h12345678 -> ready in cycle 2, `cpu_rdata`=32'h12345678, `bus_error`=0.
- VDP write, `VDP_WAIT`=1 -> ready in cycle 3, `cpu_rdata` unchanged from the previous read.
- Flash read, `flash_read_ready` in cycle 6 with `flash_rdata`=32'hCAFEF00D -> ready in cycle 7 with that data.
- Valid held with no enable (unmapped), `TIMEOUT`=16 -> one ready and `bus_error` pulse, `cpu_rdata`=0, then IDLE.
- Reset asserted mid-WAIT of a DSP access (`DSP_WAIT`=3) -> outputs 0 immediately, no ready after release; the next RAM read completes normally in cycle 2.
- `cpu_ram_en` and `flash_read_en` high together -> flash path taken (waits for `flash_read_ready`).
